tff_toggle_scheduler: RTL and testbench
=======================================

# tff_toggle_scheduler

Round-robin scheduler that shares one bank of toggle flip-flops between several requesters. Each requester presents a toggle mask and a request. The block grants one requester at a time, applies `q <= q ^ mask` to the shared bank, acknowledges the winner and accumulates a saturating count of toggled bits. It sits between the user-input decode logic and the output pins of the tile, and is the sole writer of the flip-flop bank.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: flip-flop bank width in bits.
- `CNTW`, 16: toggle-counter width in bits.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  per-requester request level; held until acked.
- `mask`  in  NREQ*WIDTH  toggle masks; requester i owns bits `[i*WIDTH +: WIDTH]`.
- `hold`  in  1  when high, no new grant is issued.
- `clr`  in  1  synchronous clear of the flip-flop bank.
- `ack`  out  NREQ  one-hot, one-cycle acknowledge of the served requester.
- `grant_id`  out  clog2(NREQ)  index of the last granted requester.
- `busy`  out  1  high while in APPLY.
- `q`  out  WIDTH  flip-flop bank state.
- `toggle_cnt`  out  CNTW  total toggled bits, saturating.

## Operation
- FSM states:
  - IDLE: sample `req` each edge. If `req != 0` and `hold == 0`, pick the winner, latch its mask, set `grant_id` and go to APPLY. Otherwise stay in IDLE.
  - APPLY: `busy = 1` and `ack[grant_id] = 1`. At the closing edge the bank updates (`q <= q ^ latched_mask`), `toggle_cnt` updates, `ptr <= grant_id + 1` (mod NREQ), and the FSM returns to IDLE unconditionally.
- Arbitration: pick the first asserted `req` at or after `ptr`, searching upward and wrapping from NREQ-1 to 0. After reset `ptr = 0`.
- Mask capture: the mask is latched on the IDLE→APPLY edge. Changes to `mask` during APPLY are ignored.
- Zero mask: the request is still granted and acked. `q` is unchanged and the count adds 0.
- Counter: `toggle_cnt <= min(toggle_cnt + popcount(latched_mask), 2^CNTW - 1)`. Compute the addition one bit wider than CNTW, then clamp. The counter never wraps.
- `clr`:
  - When `clr` is high at an edge, `q <= 0`. This takes priority over an APPLY toggle in the same cycle.
  - In that case the toggle is discarded, but the ack is still issued and `ptr` still advances. The counter does not add that mask.
  - `clr` does not affect `toggle_cnt` or the FSM.
- `hold`:
  - Only blocks IDLE→APPLY.
  - An APPLY already in progress completes.
  - `hold` is not sampled in APPLY.
- Requester protocol:
  - Keep `req` high with a stable mask until `ack` is seen.
  - Drop `req` at the edge ending the ack cycle.
  - A requester that keeps `req` high is treated as a new request and is served again after the others, per round-robin order.

## Timing
- Reset values: `q = 0`, `ack = 0`, `busy = 0`, `grant_id = 0`, `toggle_cnt = 0`, `ptr = 0`, state IDLE.
- Reset mid-APPLY: outputs go to their reset values immediately (asynchronously). The pending toggle and count are discarded.
- Request latency, for `req` high in cycle t with the FSM in IDLE:
  - cycle t+1: `ack` and `busy` high, `grant_id` valid.
  - cycle t+2: new `q` and new `toggle_cnt` visible.
- Throughput: at most one grant every 2 cycles. With all requesters continuously asserted, each is served once every 2·NREQ cycles.
- `ack`, `busy`, `grant_id`, `q` and `toggle_cnt` are all registered; there are no combinational input-to-output paths.
- Simultaneous `req` assertions are resolved only through `ptr`; there is no fixed priority except immediately after reset.

## Test plan
- Reset, then single request: `req = 0001`, `mask0 = 0xA5` in cycle t → `ack = 0001` in t+1; `q = 0xA5` and `toggle_cnt = 4` in t+2. Repeat the same request → `q = 0x00`, `toggle_cnt = 8`.
- All four requesters held high, masks 0x01/0x02/0x04/0x08 → acks in order 0,1,2,3,0, each 2 cycles apart, with `grant_id` matching the ack. After the first four acks `q = 0x0F`.
- `clr` asserted in the APPLY cycle of a `mask = 0xFF` grant → ack still pulses and `q = 0x00` next cycle. `toggle_cnt` unchanged and the next grant goes to the following requester.
- `hold` high with `req = 1010` → no ack and `busy = 0` for 10 cycles. Drop `hold` → requester 1 acked one cycle later, then requester 3.
- Saturation with CNTW = 4: repeated `mask = 0xFF` grants → `toggle_cnt` goes 8, then 15, and stays at 15.
- `rst` pulsed asynchronously mid-APPLY → `ack`, `busy`, `q` and `toggle_cnt` go to 0 without waiting for a clock edge. After release the first grant goes to the lowest asserted index.

Source files
------------

// File: rtl/tff_toggle_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tff_toggle_scheduler_if                                              |
// | Requester-side bus of the shared toggle flip-flop scheduler.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface tff_toggle_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
);
   localparam int c_IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] mask;
   logic                  hold;
   logic                  clr;
   logic [NREQ-1:0]       ack;
   logic [c_IDW-1:0]      grant_id;
   logic                  busy;
   logic [WIDTH-1:0]      q;
   logic [CNTW-1:0]       toggle_cnt;

   modport master (
      output req, mask, hold, clr,
      input  ack, grant_id, busy, q, toggle_cnt
   );

   modport slave (
      input  req, mask, hold, clr,
      output ack, grant_id, busy, q, toggle_cnt
   );
endinterface
`default_nettype wire

// File: rtl/tff_toggle_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tff_toggle_scheduler                                                 |
// | Round-robin arbiter sharing one toggle flip-flop bank among NREQ     |
// | requesters, with a saturating count of toggled bits.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tff_toggle_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
) (
   input  wire logic               clk,
   input  wire logic               rst,
   tff_toggle_scheduler_if.slave   sched
);
   localparam int c_IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [0:0] c_ST_IDLE  = 1'b0;
   localparam logic [0:0] c_ST_APPLY = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [c_IDW-1:0] ptr_q;
   logic [c_IDW-1:0] grant_id_q;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] bank_q;
   logic [CNTW-1:0]  cnt_q;

   logic [c_IDW-1:0] win_id;
   logic             win_vld;
   logic             grant_go;
   logic             apply_en;
   logic [CNTW:0]    pop_sum;
   logic [CNTW:0]    cnt_sum;
   logic [CNTW-1:0]  cnt_sat;

   // Scanning downward leaves the lowest offset from ptr as the final winner.
   always_comb begin
      int k;
      k       = 0;
      win_id  = '0;
      win_vld = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         k = (int'(ptr_q) + i) % NREQ;
         if (sched.req[k]) begin
            win_vld = 1'b1;
            win_id  = c_IDW'(k);
         end
      end
   end

   assign grant_go = (state_q == c_ST_IDLE) && win_vld && !sched.hold;
   assign apply_en = (state_q == c_ST_APPLY);

   always_comb begin
      pop_sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop_sum = pop_sum + (CNTW + 1)'(mask_q[i]);
      end
   end

   assign cnt_sum = {1'b0, cnt_q} + pop_sum;
   assign cnt_sat = cnt_sum[CNTW] ? {CNTW{1'b1}} : cnt_sum[CNTW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= c_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_IDLE:  if (grant_go) state_d = c_ST_APPLY;
         c_ST_APPLY: state_d = c_ST_IDLE;
         default:    state_d = c_ST_IDLE;
      endcase
   end

   always_comb begin
      sched.busy       = apply_en;
      sched.ack        = '0;
      if (apply_en) begin
         sched.ack[grant_id_q] = 1'b1;
      end
      sched.grant_id   = grant_id_q;
      sched.q          = bank_q;
      sched.toggle_cnt = cnt_q;
   end

   // clr wins over the toggle; the grant itself (ack, ptr) still completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= '0;
         grant_id_q <= '0;
         mask_q     <= '0;
         bank_q     <= '0;
         cnt_q      <= '0;
      end else begin
         if (grant_go) begin
            grant_id_q <= win_id;
            mask_q     <= sched.mask[int'(win_id) * WIDTH +: WIDTH];
         end
         if (apply_en) begin
            ptr_q <= (grant_id_q == c_IDW'(NREQ - 1)) ? '0 : grant_id_q + c_IDW'(1);
         end
         if (sched.clr) begin
            bank_q <= '0;
         end else if (apply_en) begin
            bank_q <= bank_q ^ mask_q;
         end
         if (apply_en && !sched.clr) begin
            cnt_q <= cnt_sat;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_tff_toggle_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tff_toggle_scheduler                                              |
// | Directed bench for the round-robin toggle flip-flop scheduler.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_tff_toggle_scheduler;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   tff_toggle_scheduler_if #(.NREQ(4), .WIDTH(8), .CNTW(16)) mif ();
   tff_toggle_scheduler_if #(.NREQ(4), .WIDTH(8), .CNTW(4))  sif ();

   tff_toggle_scheduler #(.NREQ(4), .WIDTH(8), .CNTW(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .sched (mif)
   );

   tff_toggle_scheduler #(.NREQ(4), .WIDTH(8), .CNTW(4)) u_sat (
      .clk   (clk),
      .rst   (rst),
      .sched (sif)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mask(input int idx, input logic [7:0] m);
      mif.mask[idx*8 +: 8] = m;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] sat_exp [3];
      sat_exp[0] = 4'd8;
      sat_exp[1] = 4'd15;
      sat_exp[2] = 4'd15;

      rst      = 1'b1;
      mif.req  = '0;
      mif.mask = '0;
      mif.hold = 1'b0;
      mif.clr  = 1'b0;
      sif.req  = '0;
      sif.mask = 32'h0000_00FF;
      sif.hold = 1'b0;
      sif.clr  = 1'b0;
      #2;
      check("rst_ack",  32'(mif.ack),        32'h0);
      check("rst_busy", 32'(mif.busy),       32'h0);
      check("rst_gid",  32'(mif.grant_id),   32'h0);
      check("rst_q",    32'(mif.q),          32'h0);
      check("rst_cnt",  32'(mif.toggle_cnt), 32'h0);
      step();
      step();
      rst = 1'b0;

      // single request, then the same request again
      mif.req = 4'b0001;
      set_mask(0, 8'hA5);
      step();
      check("t1_ack",  32'(mif.ack),  32'h1);
      check("t1_busy", 32'(mif.busy), 32'h1);
      mif.req = '0;
      step();
      check("t1_q",   32'(mif.q),          32'hA5);
      check("t1_cnt", 32'(mif.toggle_cnt), 32'd4);
      check("t1_idle", 32'(mif.busy),      32'h0);
      mif.req = 4'b0001;
      step();
      check("t1b_ack", 32'(mif.ack), 32'h1);
      mif.req = '0;
      step();
      check("t1b_q",   32'(mif.q),          32'h00);
      check("t1b_cnt", 32'(mif.toggle_cnt), 32'd8);

      // all four requesters held high
      pulse_reset();
      set_mask(0, 8'h01);
      set_mask(1, 8'h02);
      set_mask(2, 8'h04);
      set_mask(3, 8'h08);
      mif.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         check("rr_ack", 32'(mif.ack),      32'(1 << (k % 4)));
         check("rr_gid", 32'(mif.grant_id), 32'(k % 4));
         step();
         check("rr_gap", 32'({mif.ack, mif.busy}), 32'h0);
         if (k == 3) check("rr_q4", 32'(mif.q), 32'h0F);
      end
      mif.req = '0;
      check("rr_q5",   32'(mif.q),          32'h0E);
      check("rr_cnt5", 32'(mif.toggle_cnt), 32'd5);

      // clr during APPLY of a 0xFF grant
      mif.req = 4'b0010;
      set_mask(1, 8'hFF);
      step();
      check("clr_ack", 32'(mif.ack), 32'h2);
      mif.clr = 1'b1;
      mif.req = '0;
      step();
      mif.clr = 1'b0;
      check("clr_q",   32'(mif.q),          32'h00);
      check("clr_cnt", 32'(mif.toggle_cnt), 32'd5);
      mif.req = 4'b1111;
      step();
      check("clr_next_gid", 32'(mif.grant_id), 32'd2);
      check("clr_next_ack", 32'(mif.ack),      32'h4);
      mif.req = '0;
      step();
      check("clr_next_q",   32'(mif.q),          32'h04);
      check("clr_next_cnt", 32'(mif.toggle_cnt), 32'd6);

      // hold blocks new grants
      pulse_reset();
      set_mask(1, 8'h02);
      set_mask(3, 8'h08);
      mif.hold = 1'b1;
      mif.req  = 4'b1010;
      for (int k = 0; k < 10; k++) begin
         step();
         check("hold_quiet", 32'({mif.ack, mif.busy}), 32'h0);
      end
      mif.hold = 1'b0;
      step();
      check("hold_ack1", 32'(mif.ack),      32'h2);
      check("hold_gid1", 32'(mif.grant_id), 32'd1);
      mif.req = 4'b1000;
      step();
      step();
      check("hold_ack3", 32'(mif.ack),      32'h8);
      check("hold_gid3", 32'(mif.grant_id), 32'd3);
      mif.req = '0;
      step();
      check("hold_q",   32'(mif.q),          32'h0A);
      check("hold_cnt", 32'(mif.toggle_cnt), 32'd2);

      // saturation on the 4-bit counter instance
      for (int n = 0; n < 3; n++) begin
         sif.req = 4'b0001;
         step();
         sif.req = '0;
         step();
         check("sat_cnt", 32'(sif.toggle_cnt), 32'(sat_exp[n]));
         check("sat_q",   32'(sif.q),          (n % 2 == 0) ? 32'hFF : 32'h00);
      end

      // asynchronous reset in the middle of APPLY
      set_mask(0, 8'h01);
      set_mask(2, 8'h04);
      mif.req = 4'b0100;
      step();
      check("ar_busy_pre", 32'(mif.busy), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("ar_ack",  32'(mif.ack),        32'h0);
      check("ar_busy", 32'(mif.busy),       32'h0);
      check("ar_q",    32'(mif.q),          32'h0);
      check("ar_cnt",  32'(mif.toggle_cnt), 32'h0);
      check("ar_gid",  32'(mif.grant_id),   32'h0);
      mif.req = 4'b0101;
      #3;
      rst = 1'b0;
      step();
      check("ar_first_ack", 32'(mif.ack), 32'h1);
      mif.req = 4'b0100;
      step();
      mif.req = '0;
      check("ar_q_after",   32'(mif.q),          32'h01);
      check("ar_cnt_after", 32'(mif.toggle_cnt), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
